// File: rtl/fifo_wr_if.sv
// Write-side port bundle of the asynchronous FIFO.
// The producer drives winc; the read domain supplies its Gray pointer.
// The write block returns the memory write strobe/address, its own
// Gray pointer and the full / almost_full flags.
//
// Handshake: a write is accepted on a wclk rising edge exactly when
// winc=1 and full=0. wclken is that acceptance term, and waddr is the
// slot written on that edge. winc while full is dropped, not queued.
interface fifo_wr_if #(
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = ADDR_WIDTH + 1;

    logic                  winc;
    logic [PW-1:0]         gray_rd_ptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wclken;
    logic [PW-1:0]         gray_wr_ptr;
    logic                  full;
    logic                  almost_full;

    // Producer / read-domain side.
    modport master (
        output winc,
        output gray_rd_ptr,
        input  waddr,
        input  wclken,
        input  gray_wr_ptr,
        input  full,
        input  almost_full
    );

    // Write-pointer block side.
    modport slave (
        input  winc,
        input  gray_rd_ptr,
        output waddr,
        output wclken,
        output gray_wr_ptr,
        output full,
        output almost_full
    );
endinterface

// File: rtl/fifo_wr.sv
// Write-pointer and full-flag logic of an asynchronous FIFO.
// Keeps a binary write pointer plus its registered Gray copy, brings the
// read-domain Gray pointer across with a two-flop synchronizer and
// derives full (pointer compare) and a registered almost_full.
module fifo_wr #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic        wclk,
    input  logic        wrst_n,
    fifo_wr_if.slave    bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_gray_wr_ptr;
    logic [PW-1:0] r_rq1;
    logic [PW-1:0] r_rq2;
    logic          r_almost_full;

    logic          w_full;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_ptr_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_count_next;

    // Full when the write pointer has lapped the synchronized read pointer:
    // Gray form differs only in the two top bits.
    assign w_full  = (r_gray_wr_ptr == {~r_rq2[PW-1:PW-2], r_rq2[PW-3:0]});
    assign w_wr_en = bus.winc & ~w_full;

    assign w_wr_ptr_next = r_wr_ptr + {{(PW-1){1'b0}}, w_wr_en};
    assign w_gray_next   = w_wr_ptr_next ^ (w_wr_ptr_next >> 1);

    // Gray-to-binary of the synchronized read pointer: each binary bit is
    // the XOR of all Gray bits at or above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rd_bin[i] = ^(r_rq2 >> i);
        end
    end

    // Fill level after this edge; modulo arithmetic handles pointer wrap.
    assign w_count_next = w_wr_ptr_next - w_rd_bin;

    // Write pointer and its Gray copy advance together on an accepted write.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wr_ptr      <= '0;
            r_gray_wr_ptr <= '0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_next;
            r_gray_wr_ptr <= w_gray_next;
        end
    end

    // Two-flop synchronizer for the read-domain Gray pointer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= bus.gray_rd_ptr;
            r_rq2 <= r_rq1;
        end
    end

    // Registered almost_full from the post-edge fill level.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_next >= AF_LEVEL);
        end
    end

    assign bus.waddr       = r_wr_ptr[ADDR_WIDTH-1:0];
    assign bus.wclken      = w_wr_en;
    assign bus.gray_wr_ptr = r_gray_wr_ptr;
    assign bus.full        = w_full;
    assign bus.almost_full = r_almost_full;
endmodule

// File: tb/tb_fifo_wr.sv
// Directed bench for fifo_wr (ADDR_WIDTH=3, AF_MARGIN=2).
module tb_fifo_wr;
    logic wclk;
    logic wrst_n;

    int n_checks;
    int n_pass;

    fifo_wr_if #(.ADDR_WIDTH(3)) bus ();

    fifo_wr #(.ADDR_WIDTH(3), .AF_MARGIN(2)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    // Clock and reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Expected Gray write pointer after each of the first 8 writes.
    logic [3:0] gray_tab [8];
    initial begin
        gray_tab[0] = 4'b0001; gray_tab[1] = 4'b0011;
        gray_tab[2] = 4'b0010; gray_tab[3] = 4'b0110;
        gray_tab[4] = 4'b0111; gray_tab[5] = 4'b0101;
        gray_tab[6] = 4'b0100; gray_tab[7] = 4'b1100;
    end

    // Read pointers 1..16 (mod 16) in Gray form, for the wrap scenario.
    logic [3:0] rd_gray_tab [16];
    initial begin
        rd_gray_tab[0]  = 4'b0001; rd_gray_tab[1]  = 4'b0011;
        rd_gray_tab[2]  = 4'b0010; rd_gray_tab[3]  = 4'b0110;
        rd_gray_tab[4]  = 4'b0111; rd_gray_tab[5]  = 4'b0101;
        rd_gray_tab[6]  = 4'b0100; rd_gray_tab[7]  = 4'b1100;
        rd_gray_tab[8]  = 4'b1101; rd_gray_tab[9]  = 4'b1111;
        rd_gray_tab[10] = 4'b1110; rd_gray_tab[11] = 4'b1010;
        rd_gray_tab[12] = 4'b1011; rd_gray_tab[13] = 4'b1001;
        rd_gray_tab[14] = 4'b1000; rd_gray_tab[15] = 4'b0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One rising edge, then settle past it before sampling.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_waddr"},  32'(bus.waddr),       32'd0);
        check({tag, "_gray"},   32'(bus.gray_wr_ptr), 32'd0);
        check({tag, "_full"},   32'(bus.full),        32'd0);
        check({tag, "_af"},     32'(bus.almost_full), 32'd0);
        check({tag, "_wclken"}, 32'(bus.wclken),      32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.winc        = 1'b0;
        bus.gray_rd_ptr = 4'b0000;

        // Reset with no clock edge yet
        wrst_n = 1'b1;
        #1 wrst_n = 1'b0;
        #1 check_all_zero("por");
        tick();
        tick();
        #2 wrst_n = 1'b1;
        tick();
        check_all_zero("post_rst");

        // Fill 8 writes
        for (int i = 0; i < 8; i++) begin
            bus.winc = 1'b1;
            #1;
            check($sformatf("fill%0d_waddr", i),  32'(bus.waddr),  32'(i));
            check($sformatf("fill%0d_wclken", i), 32'(bus.wclken), 32'd1);
            tick();
            check($sformatf("fill%0d_gray", i), 32'(bus.gray_wr_ptr), 32'(gray_tab[i]));
            check($sformatf("fill%0d_af", i),   32'(bus.almost_full), (i >= 5) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d_full", i), 32'(bus.full),        (i == 7) ? 32'd1 : 32'd0);
        end

        // Write while full: dropped
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ovf%0d_wclken", i), 32'(bus.wclken), 32'd0);
            check($sformatf("ovf%0d_waddr", i),  32'(bus.waddr),  32'd0);
            tick();
            check($sformatf("ovf%0d_gray", i), 32'(bus.gray_wr_ptr), 32'hC);
            check($sformatf("ovf%0d_full", i), 32'(bus.full),        32'd1);
        end

        // Read side frees one slot: full drops after exactly 2 edges
        bus.winc        = 1'b0;
        bus.gray_rd_ptr = 4'b0001;
        tick();
        check("free_e1_full", 32'(bus.full), 32'd1);
        tick();
        check("free_e2_full", 32'(bus.full), 32'd0);
        check("free_e2_af",   32'(bus.almost_full), 32'd1);
        bus.winc = 1'b1;
        #1;
        check("refill_waddr",  32'(bus.waddr),  32'd0);
        check("refill_wclken", 32'(bus.wclken), 32'd1);
        tick();
        bus.winc = 1'b0;
        check("refill_gray", 32'(bus.gray_wr_ptr), 32'hD);
        check("refill_full", 32'(bus.full),        32'd1);

        // Fresh reset, then 16 writes each followed by a matching read advance
        #2 wrst_n = 1'b0;
        #1 check_all_zero("rst2");
        #2 wrst_n = 1'b1;
        bus.gray_rd_ptr = 4'b0000;
        tick();
        for (int k = 0; k < 16; k++) begin
            bus.winc = 1'b1;
            #1;
            check($sformatf("wrap%0d_waddr", k),  32'(bus.waddr),  32'(k % 8));
            check($sformatf("wrap%0d_wclken", k), 32'(bus.wclken), 32'd1);
            tick();
            bus.winc = 1'b0;
            if (k == 14) check("wrap_gray_15", 32'(bus.gray_wr_ptr), 32'h8);
            if (k == 15) check("wrap_gray_0",  32'(bus.gray_wr_ptr), 32'h0);
            bus.gray_rd_ptr = rd_gray_tab[k];
            tick();
            tick();
            tick();
            check($sformatf("wrap%0d_full", k), 32'(bus.full),        32'd0);
            check($sformatf("wrap%0d_af", k),   32'(bus.almost_full), 32'd0);
        end

        // Mid-fill asynchronous reset at count=5
        for (int i = 0; i < 5; i++) begin
            bus.winc = 1'b1;
            tick();
        end
        bus.winc = 1'b0;
        check("mid_waddr_5", 32'(bus.waddr), 32'd5);
        check("mid_af_5",    32'(bus.almost_full), 32'd0);
        #2 wrst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        #2 wrst_n = 1'b1;
        tick();
        bus.winc = 1'b1;
        #1;
        check("after_rst_waddr",  32'(bus.waddr),  32'd0);
        check("after_rst_wclken", 32'(bus.wclken), 32'd1);
        tick();
        bus.winc = 1'b0;
        check("after_rst_gray", 32'(bus.gray_wr_ptr), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
